// File: rtl/fcs_insert.sv
// fcs_insert: appends the Ethernet FCS (CRC-32) to an 8-lane byte stream
//   crc32      : sliced reflected CRC-32 (poly 0x04C11DB7), combinational out_crc
//                covers the current crc state plus the bytes presented this cycle
//   fcs_insert : clk, rst_n (sync, active-low);
//                s_data/s_keep/s_valid/s_last/s_ready  upstream beat
//                m_data/m_keep/m_valid/m_last/m_ready  downstream beat, FCS appended
module crc32 #(
    parameter int          SLICE_LENGTH     = 8,
    parameter int          MAX_SLICE_LENGTH = 16,
    parameter bit          REGISTER_OUTPUT  = 1'b0,
    parameter bit          INVERT_OUTPUT    = 1'b1,
    parameter logic [31:0] INITIAL_CRC      = 32'hFFFFFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*SLICE_LENGTH-1:0] in_data,
    input  logic [SLICE_LENGTH-1:0]   in_valid,
    output logic [31:0]               out_crc
);
    logic [31:0] crc_q, crc_d, res;
    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < SLICE_LENGTH; i++) begin
            if (i < MAX_SLICE_LENGTH && in_valid[i]) begin
                crc_d = crc_d ^ {24'h0, in_data[8*i +: 8]};
                for (int b = 0; b < 8; b++)
                    crc_d = crc_d[0] ? (crc_d >> 1) ^ 32'hEDB88320 : crc_d >> 1;
            end
        end
    end
    assign res = INVERT_OUTPUT ? ~crc_d : crc_d;
    // Reseed takes priority over the update, so out_crc still reflects the final bytes.
    always_ff @(posedge clk) crc_q <= rst ? INITIAL_CRC : crc_d;
    generate
        if (REGISTER_OUTPUT) begin : g_reg
            logic [31:0] out_q;
            always_ff @(posedge clk) out_q <= rst ? '0 : res;
            assign out_crc = out_q;
        end else begin : g_comb
            assign out_crc = res;
        end
    endgenerate
endmodule

module fcs_insert #(
    parameter logic [31:0] INITIAL_CRC      = 32'hFFFFFFFF,
    parameter int          MAX_SLICE_LENGTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_data,
    input  logic [7:0]  s_keep,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] m_data,
    output logic [7:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
);
    typedef enum logic {PASS, EXTRA} state_t;
    state_t state_q, state_d;
    logic accept, xfer;
    logic [3:0] k;
    logic [31:0] fcs;
    logic [63:0] data_m;
    logic [95:0] ext;
    logic [63:0] m_data_q, m_data_d;
    logic [7:0] m_keep_q, m_keep_d, extra_keep_q, extra_keep_d;
    logic m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [31:0] extra_q, extra_d;
    assign s_ready = (~m_valid_q | m_ready) & (state_q != EXTRA);
    assign accept = s_valid & s_ready;
    assign xfer = m_valid_q & m_ready;
    crc32 #(
        .SLICE_LENGTH(8),
        .MAX_SLICE_LENGTH(MAX_SLICE_LENGTH),
        .REGISTER_OUTPUT(1'b0),
        .INVERT_OUTPUT(1'b1),
        .INITIAL_CRC(INITIAL_CRC)
    ) u_crc (
        .clk(clk),
        .rst(~rst_n | (accept & s_last)),
        .in_data(s_data),
        .in_valid(accept ? s_keep : 8'h00),
        .out_crc(fcs)
    );
    always_comb begin
        k = '0;
        data_m = '0;
        for (int i = 0; i < 8; i++) begin
            k = k + 4'(s_keep[i]);
            data_m[8*i +: 8] = s_keep[i] ? s_data[8*i +: 8] : 8'h00;
        end
    end
    // FCS placed right after the last valid lane; bytes spilling past lane 7 land in ext[95:64].
    assign ext = {32'h0, data_m} | ({64'h0, s_last ? fcs : 32'h0} << {k, 3'b000});
    always_ff @(posedge clk) state_q <= !rst_n ? PASS : state_d;
    always_comb begin
        state_d = state_q;
        if (state_q == PASS && accept && s_last && k > 4'd4) state_d = EXTRA;
        if (state_q == EXTRA && xfer) state_d = PASS;
    end
    always_comb begin
        m_valid_d = (state_q == EXTRA) | accept | (m_valid_q & ~m_ready);
        m_data_d = state_q == EXTRA ? (xfer ? {32'h0, extra_q} : m_data_q) : accept ? ext[63:0] : m_data_q;
        m_keep_d = state_q == EXTRA ? (xfer ? extra_keep_q : m_keep_q) :
                   accept ? (!s_last ? s_keep : k > 4'd4 ? 8'hFF : 8'hFF >> (4'd4 - k)) : m_keep_q;
        m_last_d = state_q == EXTRA ? (xfer | m_last_q) : accept ? (s_last & k <= 4'd4) : m_last_q;
        extra_d = accept ? ext[95:64] : extra_q;
        extra_keep_d = accept ? 8'hFF >> (4'd12 - k) : extra_keep_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q <= '0;
            m_keep_q <= '0;
            m_last_q <= 1'b0;
            extra_q <= '0;
            extra_keep_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q <= m_data_d;
            m_keep_q <= m_keep_d;
            m_last_q <= m_last_d;
            extra_q <= extra_d;
            extra_keep_q <= extra_keep_d;
        end
    end
    assign m_data = m_data_q;
    assign m_keep = m_keep_q;
    assign m_valid = m_valid_q;
    assign m_last = m_last_q;
endmodule
